mul_seq_32: RTL and testbench

- Multi-cycle 32x32 -> 64-bit multiply sequencer for the execute stage.
- Internally instantiates one Adder_CLA_32bit and drives it through radix-2 shift-and-add.
- Also uses the adder for two's-complement operand/result fix-up, so there is no second adder.
- Fixed latency, start/busy/done handshake; result held stable until the next accepted start.

---
 rtl/mul_seq_32.sv | 191 +++++++++++++++++++
 tb/tb_mul_seq_32.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_32.sv
// Radix-2 shift-and-add 32x32->64 multiplier sequencer built around one
// carry-lookahead adder, which also performs the two's-complement fix-ups.
module Adder_CLA_32bit (
  input  logic [0:31] a,
  input  logic [0:31] b,
  input  logic        inC,
  output logic [0:31] s,
  output logic        outC
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic        gg;
  logic        pp;

  // internal vectors are LSB-first; ports are MSB-first (bit 0 = MSB)
  always_comb begin
    g = '0;
    p = '0;
    c = '0;
    s = '0;
    gg = 1'b0;
    pp = 1'b0;
    c[0] = inC;
    for (int i = 0; i < 32; i++) begin
      g[i] = a[31-i] & b[31-i];
      p[i] = a[31-i] ^ b[31-i];
    end
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp = &p[4*k +: 4];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      c[4*k+4] = gg | (pp & c[4*k]);
    end
    for (int i = 0; i < 32; i++)
      s[31-i] = p[i] ^ c[i];
    outC = c[32];
  end
endmodule

module mul_seq_32 #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [0:31] a,
  input  logic [0:31] b,
  output logic        busy,
  output logic        done,
  output logic [0:31] prod_hi,
  output logic [0:31] prod_lo
);
  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_RUN,
    S_FIXL, S_FIXH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [0:31] mcand_q, mcand_d;
  logic [0:31] q_q, q_d;
  logic [0:31] acc_q, acc_d;
  logic [0:31] hi_q, hi_d;
  logic [0:31] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        neg_q, neg_d;
  logic        cy_q, cy_d;

  logic [0:31] add_a, add_b, add_s;
  logic        add_ci, add_co;

  Adder_CLA_32bit u_add (
    .a    (add_a),
    .b    (add_b),
    .inC  (add_ci),
    .s    (add_s),
    .outC (add_co)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    cy_d    = cy_q;
    add_a   = '0;
    add_b   = '0;
    add_ci  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          q_d     = b;
          sgn_d   = signed_op & SIGNED_EN;
          neg_d   = signed_op & SIGNED_EN & (a[0] ^ b[0]);
          state_d = S_NEGA;
        end
      end
      S_NEGA: begin
        add_a  = ~mcand_q;
        add_ci = 1'b1;
        if (sgn_q & mcand_q[0])
          mcand_d = add_s;
        state_d = S_NEGB;
      end
      S_NEGB: begin
        add_a  = ~q_q;
        add_ci = 1'b1;
        if (sgn_q & q_q[0])
          q_d = add_s;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        add_a = acc_q;
        add_b = q_q[31] ? mcand_q : '0;
        acc_d = {add_co, add_s[0:30]};
        q_d   = {add_s[31], q_q[0:30]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = S_FIXL;
      end
      S_FIXL: begin
        add_a  = ~q_q;
        add_ci = 1'b1;
        if (neg_q) begin
          q_d  = add_s;
          cy_d = add_co;
        end else begin
          cy_d = 1'b0;
        end
        state_d = S_FIXH;
      end
      S_FIXH: begin
        add_a  = ~acc_q;
        add_ci = cy_q;
        if (neg_q)
          acc_d = add_s;
        // product words are captured on the same edge as the high fix-up
        hi_d    = neg_q ? add_s : acc_q;
        lo_d    = q_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      cy_q    <= cy_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign prod_hi = hi_q;
  assign prod_lo = lo_q;
endmodule

// File: tb/tb_mul_seq_32.sv
// Directed and random checks of mul_seq_32 (signed and unsigned-only builds)
// against a plain-arithmetic product model.
module tb_mul_seq_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [0:31] a = '0;
  logic [0:31] b = '0;
  logic        busy, done, u_busy, u_done;
  logic [0:31] p_hi, p_lo, u_hi, u_lo;

  int checks = 0;
  int errors = 0;
  int n;

  mul_seq_32 u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .a(a), .b(b),
    .busy(busy), .done(done),
    .prod_hi(p_hi), .prod_lo(p_lo)
  );

  mul_seq_32 #(.SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_op(signed_op), .a(a), .b(b),
    .busy(u_busy), .done(u_done),
    .prod_hi(u_hi), .prod_lo(u_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] x, input logic [31:0] y, input bit s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of busy cycle 1; optionally re-asserts start
  // with other operands at busy cycle inj (must be ignored).
  task automatic wait_done(input string tag, input int inj,
                           input logic [63:0] hold);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      if (n == inj) begin
        chk({tag, "_hold"}, {p_hi, p_lo}, hold);
        start = 1'b1;
        a = $urandom;
        b = $urandom;
      end else if (inj != 0) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (inj != 0) start = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'd37);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    chk({tag, "_udone"}, {63'b0, u_done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x,
                        input logic [31:0] y, input bit s, input int inj);
    logic [63:0] hold;
    hold = {p_hi, p_lo};
    @(negedge clk);
    a = x; b = y; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; signed_op = ~s;
    wait_done(tag, inj, hold);
    chk({tag, "_prod"}, {p_hi, p_lo}, ref_mul(x, y, s));
    chk({tag, "_uprod"}, {u_hi, u_lo}, ref_mul(x, y, 1'b0));
    @(negedge clk);
    chk({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] rx, ry;
    bit rs;
    #1;
    chk("rst_out", {busy, done, p_hi, p_lo}, 66'd0);
    chk("rst_uout", {u_busy, u_done, u_hi, u_lo}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {62'b0, busy, done}, 64'd0);

    run_op("ubasic", 32'h0000000A, 32'h00000005, 1'b0, 0);
    run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    run_op("smin", 32'h80000000, 32'h80000000, 1'b1, 0);
    run_op("smix", 32'hFFFFFFFD, 32'h00000007, 1'b1, 0);
    run_op("szero", 32'h00000000, 32'h80000001, 1'b1, 0);

    // back-to-back with start held high throughout
    @(negedge clk);
    a = 32'hFFFFFFFD; b = 32'h00000007; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    wait_done("b2b1", 0, 64'd0);
    chk("b2b1_prod", {p_hi, p_lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    chk("b2b_gap", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    chk("b2b_accept", {63'b0, busy}, 64'd1);
    start = 1'b0;
    wait_done("b2b2", 0, 64'd0);
    chk("b2b2_prod", {p_hi, p_lo}, 64'h00000000_00000001);
    chk("b2b2_uprod", {u_hi, u_lo}, 64'hFFFFFFFE_00000001);

    // start while busy is ignored, not queued
    run_op("ignore", 32'h12345678, 32'h9ABCDEF0, 1'b1, 10);
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    chk("ignore_noq", 64'(dones), 64'd0);

    for (int i = 0; i < 10; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom);
      if (i == 0) ry = 32'h00000000;
      run_op($sformatf("rnd%0d", i), rx, ry, rs, 0);
    end

    // asynchronous reset in the middle of RUN
    run_op("prefill", 32'h7FFFFFFF, 32'h00000003, 1'b0, 0);
    @(negedge clk);
    a = 32'h55555555; b = 32'h00000077; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 17; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", {busy, done, p_hi, p_lo}, 66'd0);
    chk("mid_urst", {u_busy, u_done, u_hi, u_lo}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    chk("mid_rst_nodone", 64'(dones), 64'd0);
    run_op("after_rst", 32'h00000002, 32'h00000003, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
